// File: rtl/hamming_tx_arbiter.sv
// Round-robin arbiter that shares one Hamming(7,4) encoder between two byte sources.
// Ports: clk/rst, req_valid/req_data0/req_data1/req_ready, inject_en/inject_bit, out_* stream.

module hamming_encoder (
  input  logic [3:0] d,
  output logic [6:0] code
);
  assign code = {
    d[3],
    d[2],
    d[1],
    d[1] ^ d[2] ^ d[3],
    d[0],
    d[0] ^ d[2] ^ d[3],
    d[0] ^ d[1] ^ d[3]
  };
endmodule

module hamming_tx_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  input  logic       inject_en,
  input  logic [2:0] inject_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_code,
  output logic       out_src,
  output logic       out_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       prio_q;
  logic [3:0] hi_q;
  logic [6:0] mask_q;

  logic       accept;
  logic       gnt_src;
  logic [7:0] gnt_data;
  logic [6:0] mask_new;
  logic [3:0] enc_in;
  logic [6:0] enc_out;
  logic       hs;

  logic       valid_d;
  logic [6:0] code_d;
  logic       src_d;
  logic       last_d;

  always_comb begin
    req_ready = 2'b00;
    if (!rst && state_q == IDLE) begin
      unique case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = prio_q ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign accept   = |req_ready;
  assign gnt_src  = req_ready[1];
  assign gnt_data = gnt_src ? req_data1 : req_data0;
  assign hs       = out_valid && out_ready;

  always_comb begin
    mask_new = '0;
    if (inject_en && inject_bit != 3'd7)
      mask_new = 7'(1) << inject_bit;
  end

  // Low nibble is encoded straight from the granted input at accept;
  // the encoder is then reused for the latched high nibble.
  assign enc_in = (state_q == IDLE) ? gnt_data[3:0] : hi_q;

  hamming_encoder u_enc (
    .d    (enc_in),
    .code (enc_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      hi_q      <= '0;
      mask_q    <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_src   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      out_code  <= code_d;
      out_src   <= src_d;
      out_last  <= last_d;
      if (accept) begin
        hi_q   <= gnt_data[7:4];
        mask_q <= mask_new;
        prio_q <= ~gnt_src;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LO;
      LO:      if (hs) state_d = HI;
      HI:      if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = out_valid;
    code_d  = out_code;
    src_d   = out_src;
    last_d  = out_last;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          valid_d = 1'b1;
          code_d  = enc_out ^ mask_new;
          src_d   = gnt_src;
          last_d  = 1'b0;
        end
      end
      LO: begin
        if (hs) begin
          code_d = enc_out ^ mask_q;
          last_d = 1'b1;
        end
      end
      HI: begin
        if (hs) begin
          valid_d = 1'b0;
          code_d  = '0;
          src_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: begin
        valid_d = 1'b0;
        code_d  = '0;
        src_d   = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

endmodule
